// File: rtl/select_next_hop.sv
// Neighbour-table scanner for the Q-routing action selector: finds the best overall
// next hop and the best in-cluster cluster-head sink by walking local word memory.
module select_next_hop #(
    parameter int unsigned WORD_WIDTH  = 16,
    parameter int unsigned NT_BASE     = 16'h10,
    parameter int unsigned ENTRY_WORDS = 4,
    parameter int unsigned MAX_NBR     = 8,
    parameter int unsigned NONE        = 16'd65
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] my_cluster,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] address,
    output logic                  rd_en,
    output logic [WORD_WIDTH-1:0] nexthop,
    output logic [WORD_WIDTH-1:0] nextsinks,
    output logic [WORD_WIDTH-1:0] best_q,
    output logic                  done
);

    localparam logic [WORD_WIDTH-1:0] BASE_W = WORD_WIDTH'(NT_BASE);
    localparam logic [WORD_WIDTH-1:0] MAX_W  = WORD_WIDTH'(MAX_NBR);
    localparam logic [WORD_WIDTH-1:0] NONE_W = WORD_WIDTH'(NONE);
    localparam logic [1:0]            LAST_WORD = 2'(ENTRY_WORDS - 1);

    typedef enum logic [2:0] {IDLE, RDCNT, LDCNT, RDENT, EVAL, NEXT, DONE} state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] address_q, address_d;
    logic [WORD_WIDTH-1:0] count_q, count_d;
    logic [WORD_WIDTH-1:0] idx_q, idx_d;
    logic [1:0]            sub_q, sub_d;
    logic [WORD_WIDTH-1:0] cluster_q, cluster_d;
    logic [WORD_WIDTH-1:0] entId_q, entId_d;
    logic [WORD_WIDTH-1:0] entCl_q, entCl_d;
    logic                  entCh_q, entCh_d;
    logic [WORD_WIDTH-1:0] nexthop_q, nexthop_d;
    logic [WORD_WIDTH-1:0] nextsinks_q, nextsinks_d;
    logic [WORD_WIDTH-1:0] bestQ_q, bestQ_d;
    logic [WORD_WIDTH-1:0] sinkQ_q, sinkQ_d;
    logic                  haveBest_q, haveBest_d;
    logic                  haveSink_q, haveSink_d;

    logic [WORD_WIDTH-1:0] countClamped;
    logic [WORD_WIDTH-1:0] idxNext;
    logic                  startOk;

    assign countClamped = (data_in > MAX_W) ? MAX_W : data_in;
    assign idxNext      = idx_q + WORD_WIDTH'(1);
    assign startOk      = start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= IDLE;
            address_q   <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            sub_q       <= '0;
            cluster_q   <= '0;
            entId_q     <= '0;
            entCl_q     <= '0;
            entCh_q     <= 1'b0;
            nexthop_q   <= NONE_W;
            nextsinks_q <= NONE_W;
            bestQ_q     <= '0;
            sinkQ_q     <= '0;
            haveBest_q  <= 1'b0;
            haveSink_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            sub_q       <= sub_d;
            cluster_q   <= cluster_d;
            entId_q     <= entId_d;
            entCl_q     <= entCl_d;
            entCh_q     <= entCh_d;
            nexthop_q   <= nexthop_d;
            nextsinks_q <= nextsinks_d;
            bestQ_q     <= bestQ_d;
            sinkQ_q     <= sinkQ_d;
            haveBest_q  <= haveBest_d;
            haveSink_q  <= haveSink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RDCNT;
            RDCNT:   state_d = LDCNT;
            LDCNT:   state_d = (countClamped == '0) ? DONE : RDENT;
            RDENT:   if (sub_q == LAST_WORD) state_d = EVAL;
            EVAL:    state_d = NEXT;
            NEXT:    state_d = (idxNext == count_q) ? DONE : RDENT;
            DONE:    if (start) state_d = RDCNT;
            default: state_d = IDLE;
        endcase
    end

    // Entry words arrive one cycle behind their address, so the Q-value is
    // taken straight from data_in during EVAL rather than being registered.
    always_comb begin
        address_d   = address_q;
        count_d     = count_q;
        idx_d       = idx_q;
        sub_d       = sub_q;
        cluster_d   = cluster_q;
        entId_d     = entId_q;
        entCl_d     = entCl_q;
        entCh_d     = entCh_q;
        nexthop_d   = nexthop_q;
        nextsinks_d = nextsinks_q;
        bestQ_d     = bestQ_q;
        sinkQ_d     = sinkQ_q;
        haveBest_d  = haveBest_q;
        haveSink_d  = haveSink_q;

        if (startOk) begin
            address_d = BASE_W;
            cluster_d = my_cluster;
        end

        case (state_q)
            LDCNT: begin
                count_d     = countClamped;
                idx_d       = '0;
                sub_d       = '0;
                nexthop_d   = NONE_W;
                nextsinks_d = NONE_W;
                bestQ_d     = '0;
                sinkQ_d     = '0;
                haveBest_d  = 1'b0;
                haveSink_d  = 1'b0;
                if (countClamped != '0) address_d = BASE_W + WORD_WIDTH'(1);
            end
            RDENT: begin
                sub_d = sub_q + 2'd1;
                case (sub_q)
                    2'd1:    entId_d = data_in;
                    2'd2:    entCl_d = data_in;
                    2'd3:    entCh_d = data_in[0];
                    default: ;
                endcase
                if (sub_q != LAST_WORD) address_d = address_q + WORD_WIDTH'(1);
            end
            EVAL: begin
                if (entId_q != NONE_W) begin
                    if (!haveBest_q || data_in > bestQ_q) begin
                        nexthop_d  = entId_q;
                        bestQ_d    = data_in;
                        haveBest_d = 1'b1;
                    end
                    if (entCh_q && entCl_q == cluster_q &&
                        (!haveSink_q || data_in > sinkQ_q)) begin
                        nextsinks_d = entId_q;
                        sinkQ_d     = data_in;
                        haveSink_d  = 1'b1;
                    end
                end
            end
            NEXT: begin
                idx_d = idxNext;
                sub_d = '0;
                if (idxNext != count_q) address_d = address_q + WORD_WIDTH'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_en     = (state_q == RDCNT) || (state_q == RDENT);
        done      = (state_q == DONE);
        address   = address_q;
        nexthop   = nexthop_q;
        nextsinks = nextsinks_q;
        best_q    = bestQ_q;
    end

endmodule
